db_event_ctrl: RTL and testbench

Consumer side of the button debouncer bank: takes the four debounced button levels (HS, VS, DF_UART, DF_VGA) and turns them into clean control events. Each channel produces a one-cycle press pulse, a long-press pulse, auto-repeat pulses while held, and a toggle level that flips on short presses. A single-entry event register, priority-encoded and released by a valid/ack handshake, lets a downstream controller (mode FSM or UART reporter) consume events one at a time.

---
 rtl/db_pkg.sv | 17 +
 rtl/db_event_chan.sv | 80 ++++++++
 rtl/db_event_ctrl.sv | 68 ++++++
 tb/tb_db_event_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// db_pkg: shared channel indices, event kind codes, channel FSM states and kind encoder.
package db_pkg;
    localparam int NCH = 4;
    localparam logic [1:0] CH_HS      = 2'd0;
    localparam logic [1:0] CH_VS      = 2'd1;
    localparam logic [1:0] CH_DF_UART = 2'd2;
    localparam logic [1:0] CH_DF_VGA  = 2'd3;
    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_PRESS = 2'b01;
    localparam logic [1:0] KIND_LONG  = 2'b10;
    localparam logic [1:0] KIND_REP   = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HOLD} state_t;
    // At most one pulse fires per channel per cycle; long outranks repeat outranks press.
    function automatic logic [1:0] pulse_kind(input logic press, input logic lng, input logic rep);
        return lng ? KIND_LONG : rep ? KIND_REP : press ? KIND_PRESS : KIND_NONE;
    endfunction
endpackage

// File: rtl/db_event_chan.sv
// db_event_chan: one button channel -- edge detect, press/long/repeat FSM, toggle bit.
// Ports: clk, rst (async, active-high); lvl debounced level in;
//        press_p/long_p/rep_p registered one-cycle pulses; toggle flips on short-press release.
module db_event_chan
    import db_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic press_p,
    output logic long_p,
    output logic rep_p,
    output logic toggle
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic lvl_q, press_d, long_d, rep_d, tog_d;
    logic rise;
    assign rise = lvl & ~lvl_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            press_p <= 1'b0;
            long_p  <= 1'b0;
            rep_p   <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl;
            press_p <= press_d;
            long_p  <= long_d;
            rep_p   <= rep_d;
            toggle  <= tog_d;
        end
    end
    // Release is tested before the threshold so a release on the threshold cycle wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        tog_d   = toggle;
        case (state_q)
            ST_IDLE: if (rise) begin
                state_d = ST_PRESSED;
                cnt_d   = '0;
                press_d = 1'b1;
            end
            ST_PRESSED: if (!lvl) begin
                state_d = ST_IDLE;
                tog_d   = ~toggle;
            end else if (cnt_q == HOLD_LAST) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                long_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_HOLD: if (!lvl) begin
                state_d = ST_IDLE;
            end else if (cnt_q == REP_LAST) begin
                cnt_d = '0;
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: rtl/db_event_ctrl.sv
// db_event_ctrl: four button channels feeding a priority-encoded single-entry event register.
// Ports: clk, rst (async, active-high); btn_lvl[3:0] debounced levels (HS, VS, DF_UART, DF_VGA);
//        press_p/long_p/rep_p/toggle per-channel outputs; event_valid/event_code/event_ack
//        handshake ({kind, ch}); event_ovf sticky flag for pulses that were not captured.
module db_event_ctrl
    import db_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] btn_lvl,
    output logic [NCH-1:0] press_p,
    output logic [NCH-1:0] long_p,
    output logic [NCH-1:0] rep_p,
    output logic [NCH-1:0] toggle,
    output logic           event_valid,
    output logic [3:0]     event_code,
    input  logic           event_ack,
    output logic           event_ovf
);
    logic [NCH-1:0] chan_any;
    logic [3:0] sel_code;
    logic load_ok, multi, loss;
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        db_event_chan #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .lvl    (btn_lvl[c]),
            .press_p(press_p[c]),
            .long_p (long_p[c]),
            .rep_p  (rep_p[c]),
            .toggle (toggle[c])
        );
    end
    assign chan_any = press_p | long_p | rep_p;
    // Scan high to low so the lowest active channel is the last writer.
    always_comb begin
        sel_code = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (chan_any[i]) sel_code = {pulse_kind(press_p[i], long_p[i], rep_p[i]), 2'(i)};
    end
    assign load_ok = !event_valid || event_ack;
    assign multi   = |(chan_any & (chan_any - NCH'(1)));
    assign loss    = multi || (|chan_any && !load_ok);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_valid <= 1'b0;
            event_code  <= '0;
            event_ovf   <= 1'b0;
        end else begin
            if (|chan_any && load_ok) begin
                event_valid <= 1'b1;
                event_code  <= sel_code;
            end else if (event_ack) begin
                event_valid <= 1'b0;
            end
            // An ack against an empty register is ignored, so it cannot clear the flag.
            event_ovf <= loss || (event_ovf && !(event_ack && event_valid));
        end
    end
endmodule

// File: tb/tb_db_event_ctrl.sv
// tb_db_event_ctrl: directed self-checking bench for db_event_ctrl with HOLD=8, REPEAT=4.
module tb_db_event_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_lvl = 4'b0;
    logic       event_ack = 1'b0;
    logic [3:0] press_p, long_p, rep_p, toggle, event_code;
    logic       event_valid, event_ovf;
    int passes = 0;
    int total  = 0;

    db_event_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_lvl    (btn_lvl),
        .press_p    (press_p),
        .long_p     (long_p),
        .rep_p      (rep_p),
        .toggle     (toggle),
        .event_valid(event_valid),
        .event_code (event_code),
        .event_ack  (event_ack),
        .event_ovf  (event_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_press"}, {4'b0, press_p}, 8'h00);
        check({tag, "_long"}, {4'b0, long_p}, 8'h00);
        check({tag, "_rep"}, {4'b0, rep_p}, 8'h00);
        check({tag, "_toggle"}, {4'b0, toggle}, 8'h00);
        check({tag, "_valid"}, {7'b0, event_valid}, 8'h00);
        check({tag, "_code"}, {4'b0, event_code}, 8'h00);
        check({tag, "_ovf"}, {7'b0, event_ovf}, 8'h00);
    endtask

    initial begin
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // short press on ch0: five high cycles
        btn_lvl = 4'b0001;
        step();
        check("t1_press", {4'b0, press_p}, 8'h01);
        check("t1_valid0", {7'b0, event_valid}, 8'h00);
        step();
        check("t1_press_low", {4'b0, press_p}, 8'h00);
        check("t1_valid", {7'b0, event_valid}, 8'h01);
        check("t1_code", {4'b0, event_code}, 8'h04);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1_nolong", {4'b0, long_p}, 8'h00);
        end
        btn_lvl = 4'b0000;
        step();
        check("t1_nolong_rel", {4'b0, long_p}, 8'h00);
        check("t1_toggle", {4'b0, toggle}, 8'h01);
        event_ack = 1'b1;
        step();
        event_ack = 1'b0;
        check("t1_acked", {7'b0, event_valid}, 8'h00);
        check("t1_ovf", {7'b0, event_ovf}, 8'h00);

        // ch2 held for 20 cycles, consumer acks every event
        btn_lvl = 4'b0100;
        step();
        check("t2_press", {4'b0, press_p}, 8'h04);
        for (int k = 1; k <= 20; k++) begin
            btn_lvl   = (k < 20) ? 4'b0100 : 4'b0000;
            event_ack = event_valid;
            step();
            check($sformatf("t2_long_%0d", k), {4'b0, long_p}, (k == 8) ? 8'h04 : 8'h00);
            check($sformatf("t2_rep_%0d", k), {4'b0, rep_p}, (k == 12 || k == 16) ? 8'h04 : 8'h00);
            if (k == 1) check("t2_code_press", {3'b0, event_valid, event_code}, 8'h16);
            if (k == 3) check("t2_drained", {7'b0, event_valid}, 8'h00);
            if (k == 9) check("t2_code_long", {3'b0, event_valid, event_code}, 8'h1A);
            if (k == 13 || k == 17) check("t2_code_rep", {3'b0, event_valid, event_code}, 8'h1E);
        end
        event_ack = 1'b0;
        check("t2_toggle", {4'b0, toggle}, 8'h01);
        check("t2_ovf", {7'b0, event_ovf}, 8'h00);
        step();

        // ch1 and ch3 rise together: ch1 wins, ch3 lost
        btn_lvl = 4'b1010;
        step();
        check("t3_press", {4'b0, press_p}, 8'h0A);
        step();
        check("t3_code", {3'b0, event_valid, event_code}, 8'h15);
        check("t3_ovf", {7'b0, event_ovf}, 8'h01);
        btn_lvl = 4'b0000;
        step();
        check("t3_toggle", {4'b0, toggle}, 8'h0B);
        check("t3_ovf_held", {7'b0, event_ovf}, 8'h01);
        event_ack = 1'b1;
        step();
        event_ack = 1'b0;
        check("t3_acked", {6'b0, event_valid, event_ovf}, 8'h00);

        // two ch0 presses without ack
        btn_lvl = 4'b0001;
        step();
        btn_lvl = 4'b0000;
        step();
        btn_lvl = 4'b0001;
        step();
        check("t4_press2", {4'b0, press_p}, 8'h01);
        btn_lvl = 4'b0000;
        step();
        check("t4_held", {3'b0, event_valid, event_code}, 8'h14);
        check("t4_ovf", {7'b0, event_ovf}, 8'h01);
        event_ack = 1'b1;
        step();
        event_ack = 1'b0;
        check("t4_acked", {6'b0, event_valid, event_ovf}, 8'h00);

        // ack coincident with a new pulse replaces the event
        btn_lvl = 4'b0001;
        step();
        btn_lvl = 4'b0000;
        step();
        btn_lvl = 4'b0010;
        step();
        event_ack = 1'b1;
        btn_lvl   = 4'b0000;
        step();
        check("t5_replace", {3'b0, event_valid, event_code}, 8'h15);
        check("t5_ovf", {7'b0, event_ovf}, 8'h00);
        check("t5_toggle", {4'b0, toggle}, 8'h08);
        step();
        event_ack = 1'b0;
        check("t5_acked", {7'b0, event_valid}, 8'h00);

        // ack with nothing pending changes nothing
        event_ack = 1'b1;
        step();
        event_ack = 1'b0;
        check("t6_state", {2'b0, event_valid, event_ovf, event_code}, 8'h05);
        check("t6_toggle", {4'b0, toggle}, 8'h08);

        // ch3 held into HOLD, then reset mid-operation
        btn_lvl = 4'b1000;
        for (int k = 0; k < 11; k++) step();
        check("t7_before_rst", {7'b0, event_valid}, 8'h01);
        rst = 1'b1;
        #1;
        check_idle_outputs("t7_rst");
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t7_no_press", {3'b0, event_valid, press_p}, 8'h00);
        end
        btn_lvl = 4'b0000;
        step();
        step();
        btn_lvl = 4'b1000;
        step();
        check("t7_repress", {4'b0, press_p}, 8'h08);
        step();
        check("t7_code", {3'b0, event_valid, event_code}, 8'h17);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
